dr_word_injector: RTL and testbench

Synchronous-to-dual-rail injector: accepts a WIDTH-bit word on a clocked valid/ready port and emits it LSB-first as a sequence of dual-rail tokens into the asynchronous buffer chain. Each token uses a four-phase return-to-zero protocol: data, then a NULL spacer. It sits directly upstream of the first dual-rail buffer stage. It drives that stage's `data_in` and consumes its `ack`. It is the boundary between the clocked front end and the self-timed pipeline.

---
 rtl/dr_word_injector_if.sv | 23 ++
 rtl/dr_word_injector.sv | 144 ++++++++++++++
 tb/tb_dr_word_injector.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dr_word_injector_if.sv
// Word-side valid/ready handshake plus the dual-rail token/ack pair
// that connects to the first asynchronous buffer stage.
interface dr_word_injector_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       data_out;
    logic             ack;
    logic             busy;
    logic             word_done;

    modport master (
        output in_data, in_valid, ack,
        input  in_ready, data_out, busy, word_done
    );

    modport slave (
        input  in_data, in_valid, ack,
        output in_ready, data_out, busy, word_done
    );
endinterface

// File: rtl/dr_word_injector.sv
// Clocked word to LSB-first dual-rail four-phase token stream (data, then NULL per bit).
// Define DR_INJ_ACK_SYNC_EN to pass ack through a 2-flop synchronizer; otherwise a single flop.
module dr_word_injector #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dr_word_injector_if.slave bus
);
    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_NULL = 2'd2
    } state_t;

    // True rail carries the bit, false rail its complement; never 11.
    function automatic logic [1:0] dr_encode(input logic b);
        return {b, ~b};
    endfunction

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] shift_r, shift_next_s, shifted_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [1:0]       data_out_r, data_out_next_s;
    logic             in_ready_r, in_ready_next_s;
    logic             busy_r, busy_next_s;
    logic             word_done_r, word_done_next_s;
    logic             ack_s;

`ifdef DR_INJ_ACK_SYNC_EN
    logic ack_meta_r;
    logic ack_sync_r;

    // Two-flop synchronizer bringing the self-timed ack into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_meta_r <= 1'b0;
            ack_sync_r <= 1'b0;
        end else begin
            ack_meta_r <= bus.ack;
            ack_sync_r <= ack_meta_r;
        end
    end
`else
    logic ack_sync_r;

    // Single capture flop for a synchronous downstream model.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_sync_r <= 1'b0;
        end else begin
            ack_sync_r <= bus.ack;
        end
    end
`endif

    assign ack_s     = ack_sync_r;
    assign shifted_s = shift_r >> 1;

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            shift_r     <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            data_out_r  <= 2'b00;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            word_done_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            shift_r     <= shift_next_s;
            cnt_r       <= cnt_next_s;
            data_out_r  <= data_out_next_s;
            in_ready_r  <= in_ready_next_s;
            busy_r      <= busy_next_s;
            word_done_r <= word_done_next_s;
        end
    end

    // Next-state and next-output logic; outputs move only on protocol transitions.
    always_comb begin
        state_next_s     = state_r;
        shift_next_s     = shift_r;
        cnt_next_s       = cnt_r;
        data_out_next_s  = data_out_r;
        word_done_next_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                data_out_next_s = 2'b00;
                if (bus.in_valid && in_ready_r) begin
                    shift_next_s    = bus.in_data;
                    cnt_next_s      = CNT_LOAD;
                    data_out_next_s = dr_encode(bus.in_data[0]);
                    state_next_s    = ST_DATA;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (ack_s) begin
                    data_out_next_s = 2'b00;
                    state_next_s    = ST_NULL;
                end else begin
                    data_out_next_s = dr_encode(shift_r[0]);
                    state_next_s    = ST_DATA;
                end
            end
            ST_NULL: begin
                data_out_next_s = 2'b00;
                if (!ack_s) begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        shift_next_s    = shifted_s;
                        cnt_next_s      = cnt_r - CNT_W'(1'b1);
                        data_out_next_s = dr_encode(shifted_s[0]);
                        state_next_s    = ST_DATA;
                    end else begin
                        word_done_next_s = 1'b1;
                        state_next_s     = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_NULL;
                end
            end
            default: begin
                data_out_next_s = 2'b00;
                state_next_s    = ST_IDLE;
            end
        endcase

        busy_next_s     = (state_next_s != ST_IDLE);
        // A still-high ack in IDLE means the downstream stage has not emptied yet.
        in_ready_next_s = (state_next_s == ST_IDLE) && !ack_s;
    end

    assign bus.data_out  = data_out_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.word_done = word_done_r;
endmodule

// File: tb/tb_dr_word_injector.sv
// Directed bench for dr_word_injector: reset, stale ack, backpressure, ack latency,
// mid-word reset, single word and back-to-back words with a delayed-ack downstream model.
module tb_dr_word_injector;
    localparam int WIDTH = 8;
`ifdef DR_INJ_ACK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic ack_auto;
    logic manual_ack;
    logic model_ack;
    int   tests = 0;
    int   fails = 0;

    logic [1:0] tok_q[$];
    int         done_cnt    = 0;
    int         illegal_cnt = 0;
    logic [1:0] exp_a5 [8];

    dr_word_injector_if #(.WIDTH(WIDTH)) bus ();

    dr_word_injector #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.ack = ack_auto ? model_ack : manual_ack;

    // Downstream stage model: acks a token / NULL two cycles after seeing it.
    initial begin
        logic p0, p1;
        p0 = 1'b0;
        p1 = 1'b0;
        model_ack = 1'b0;
        forever begin
            @(negedge clk);
            p1 = p0;
            p0 = (bus.data_out != 2'b00);
            model_ack = p1;
        end
    end

    // Token monitor: records each token emitted after a NULL, counts done pulses and 11s.
    initial begin
        logic [1:0] prev;
        prev = 2'b00;
        forever begin
            @(negedge clk);
            if (bus.data_out === 2'b11) illegal_cnt++;
            if (bus.data_out !== 2'b00 && prev === 2'b00) tok_q.push_back(bus.data_out);
            if (bus.word_done === 1'b1) done_cnt++;
            prev = bus.data_out;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: data_out==00, 1: data_out!=00, 3: word_done==1
    task automatic wait_for(input int mode, input string tag, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 300) begin
            tick();
            n++;
            case (mode)
                0:       hit = (bus.data_out === 2'b00);
                1:       hit = (bus.data_out === 2'b01 || bus.data_out === 2'b10);
                3:       hit = (bus.word_done === 1'b1);
                default: hit = 1'b1;
            endcase
        end
        if (!hit) begin
            tests++;
            fails++;
            $error("FAIL %s: timeout after %0d cycles", tag, n);
        end
    endtask

    initial begin
        int n;
        int base_tok;
        int base_done;
        int err;
        logic [1:0] held;

        exp_a5 = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
        rst_n = 1'b0;
        ack_auto = 1'b0;
        manual_ack = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (3) tick();
        check("rst_data_out", 32'(bus.data_out), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_word_done", 32'(bus.word_done), 32'h0);

        // Stale ack held through and after reset.
        rst_n = 1'b1;
        repeat (LAT + 1) tick();
        err = 0;
        repeat (8) begin
            tick();
            if (bus.in_ready !== 1'b0 || bus.data_out !== 2'b00) err++;
        end
        check("stale_ack_hold", 32'(err), 32'h0);
        manual_ack = 1'b0;
        repeat (LAT - 1) tick();
        check("stale_release_early", 32'(bus.in_ready), 32'h0);
        tick();
        check("stale_release_ready", 32'(bus.in_ready), 32'h1);

        // Word 3C under manual ack: backpressure, latency, then reset in bit 3.
        bus.in_data = 8'h3C;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("m_first_token", 32'(bus.data_out), 32'h1);
        check("m_busy", 32'(bus.busy), 32'h1);
        check("m_ready_low", 32'(bus.in_ready), 32'h0);
        held = bus.data_out;
        err = 0;
        repeat (50) begin
            tick();
            if (bus.data_out !== held || bus.busy !== 1'b1) err++;
        end
        check("backpressure_stable", 32'(err), 32'h0);
        manual_ack = 1'b1;
        wait_for(0, "m_null", n);
        check("ack_rise_latency", 32'(n), 32'(LAT));
        manual_ack = 1'b0;
        wait_for(1, "m_bit1", n);
        check("ack_fall_latency", 32'(n), 32'(LAT));
        check("m_bit1_token", 32'(bus.data_out), 32'h1);
        manual_ack = 1'b1;
        wait_for(0, "m_null1", n);
        manual_ack = 1'b0;
        wait_for(1, "m_bit2", n);
        check("m_bit2_token", 32'(bus.data_out), 32'h2);
        manual_ack = 1'b1;
        wait_for(0, "m_null2", n);
        manual_ack = 1'b0;
        wait_for(1, "m_bit3", n);
        check("m_bit3_token", 32'(bus.data_out), 32'h2);
        base_done = done_cnt;
        rst_n = 1'b0;
        tick();
        check("midrst_data_out", 32'(bus.data_out), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_word_done", 32'(bus.word_done), 32'h0);
        rst_n = 1'b1;
        tick();
        check("midrst_ready_after", 32'(bus.in_ready), 32'h1);
        tick();
        check("midrst_no_done", 32'(done_cnt - base_done), 32'h0);

        // Single word A5 with the delayed-ack downstream model.
        ack_auto = 1'b1;
        repeat (4) tick();
        base_tok = tok_q.size();
        base_done = done_cnt;
        bus.in_data = 8'hA5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("a5_first_token", 32'(bus.data_out), 32'h2);
        check("a5_busy", 32'(bus.busy), 32'h1);
        wait_for(3, "a5_done", n);
        check("a5_done_busy", 32'(bus.busy), 32'h0);
        check("a5_done_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("a5_token_count", 32'(tok_q.size() - base_tok), 32'h8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("a5_tok%0d", i), 32'(tok_q[base_tok + i]), 32'(exp_a5[i]));
        end
        check("a5_done_pulses", 32'(done_cnt - base_done), 32'h1);

        // Back-to-back 00 then FF with in_valid held high.
        base_tok = tok_q.size();
        base_done = done_cnt;
        bus.in_data = 8'h00;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = 8'hFF;
        check("b2b_w0_first", 32'(bus.data_out), 32'h1);
        wait_for(3, "b2b_done0", n);
        check("b2b_ready_on_done", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_w1_first", 32'(bus.data_out), 32'h2);
        check("b2b_w1_busy", 32'(bus.busy), 32'h1);
        wait_for(3, "b2b_done1", n);
        tick();
        check("b2b_token_count", 32'(tok_q.size() - base_tok), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("b2b_tok%0d", i), 32'(tok_q[base_tok + i]), (i < 8) ? 32'h1 : 32'h2);
        end
        check("b2b_done_pulses", 32'(done_cnt - base_done), 32'h2);
        check("never_11", 32'(illegal_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
